prefetch_unit: RTL and testbench
================================

# prefetch_unit

Parametrised instruction prefetch unit that replaces the single-cycle PC register in front of the instruction port. It issues sequential fetch requests to a variable-latency instruction memory and buffers returned words in a DEPTH-entry FIFO, each tagged with its PC. It presents instructions to decode through a valid/ready handshake. A redirect (branch, JAL, JALR) flushes the buffer and discards any responses still in flight.

## Interface
- ADDRESS_BITS, 16: width of all PC/address signals
- DEPTH, 4: FIFO entries; power of two, ≥2; also caps in-flight requests
- RESET_PC, 0: first fetch address after reset
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDRESS_BITS  fetch address
- imem_resp_valid  in  1  read data returned; in order; no backpressure
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  ADDRESS_BITS  new fetch target
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode consumes head
- inst_data  out  32  head instruction
- inst_pc  out  ADDRESS_BITS  head PC
- misaligned  out  1  sticky misaligned-redirect flag (only with PREFETCH_MISALIGN_EN; otherwise tied 0)

## Operation
- State registers:
  - fetch_pc: next request address
  - resp_pc: PC of the next kept response
  - occ: FIFO occupancy
  - outst: requests accepted but not yet answered
  - drop: responses still to discard
  - Counter width is $clog2(DEPTH+1).
- Request rule: imem_req_valid = !redirect_valid && (occ + outst < DEPTH) && !misaligned. imem_req_addr = fetch_pc.
- Accept (valid && ready): fetch_pc += 4 (wraps modulo 2^ADDRESS_BITS), outst += 1.
- Response with drop != 0: drop -= 1, outst -= 1, data discarded.
- Response with drop == 0: push {resp_pc, data}, resp_pc += 4, outst -= 1.
- Pop: inst_valid && inst_ready removes the head.
- Push and pop in the same cycle leave occ unchanged. The credit rule guarantees a push never finds the FIFO full.
- Redirect has priority over every other event in its cycle:
  - FIFO cleared (occ = 0; any pop that cycle is void)
  - fetch_pc = resp_pc = redirect_pc
  - drop = outst − (imem_resp_valid ? 1 : 0); any response arriving in the redirect cycle is discarded
  - no request is issued that cycle
- Back-to-back redirects: each one recomputes drop from the current outst. The last redirect wins.

## Timing
- Reset values:
  - fetch_pc = resp_pc = RESET_PC; occ = outst = drop = 0
  - inst_valid = 0, misaligned = 0
  - imem_req_valid = 0 while reset is asserted; it is 1 in the first cycle after release.
- Memory response earliest the cycle after request accept.
- FIFO is registered: a response in cycle t gives inst_valid in cycle t+1, so minimum fetch-to-decode latency is 2 cycles.
- After a redirect in cycle t:
  - inst_valid = 0 in cycle t+1
  - the first request, to redirect_pc, is issued in cycle t+1
- Reset asserted mid-operation: all state clears immediately. Responses to pre-reset requests must not arrive after reset; the memory is reset together with this block.
- Steady state with 1-cycle memory and continuous inst_ready: one instruction per cycle.

## Configuration
- PREFETCH_MISALIGN_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets misaligned and blocks requests until the next aligned redirect, which clears it.
  - The flush still occurs.
- PREFETCH_MISALIGN_EN undefined:
  - redirect_pc[1:0] is forced to 00.
  - misaligned is constant 0.

## Structure
- Shared package (core_pkg): ADDRESS_BITS default, RESET_PC default, and a fetch entry struct {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO with flush input, parametrised by DEPTH and entry width. It exposes occ.
- Credit and drop accounting stay in prefetch_unit.

## Test plan
- Reset release, 1-cycle memory, inst_ready=1 → requests 0x0, 0x4, 0x8…; inst_pc 0x0 appears 2 cycles after release, then one instruction per cycle.
- inst_ready=0, DEPTH=4, memory always ready → exactly 4 requests issued; imem_req_valid=0; occ=4 held until pops resume.
- 3-cycle memory latency, redirect to 0x100 with outst=2 → 2 stale responses dropped; first inst_pc=0x100, data from address 0x100.
- Redirect in the same cycle as a response and a pop → response discarded; inst_valid=0 next cycle; request to the new PC next cycle.
- imem_req_ready toggling 1/0 each cycle → no duplicate or skipped addresses; inst_pc strictly +4 per pop.
- PREFETCH_MISALIGN_EN, redirect to 0x102 → misaligned=1, no requests; later redirect to 0x200 clears it and fetch resumes at 0x200.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default address width, reset PC and the fetch entry layout.
package core_pkg;

    localparam int CORE_ADDRESS_BITS = 16;
    localparam int INSTR_BITS        = 32;
    localparam logic [CORE_ADDRESS_BITS-1:0] CORE_RESET_PC = '0;

    typedef struct packed {
        logic [CORE_ADDRESS_BITS-1:0] pc;
        logic [INSTR_BITS-1:0]        instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions; flush empties it and voids any same-cycle push or pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_occ
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_occ;
    logic             w_pop;

    assign o_valid = (r_occ != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;
    assign w_pop   = i_pop && o_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_occ <= r_occ + CW'(i_push) - CW'(w_pop);
        end
    end

    // NOTE: storage has no reset; occupancy alone decides what is valid, so clearing it buys nothing.
    always_ff @(posedge clock) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: credit-limited sequential fetch, in-order response buffering, redirect flush.
// Optional PREFETCH_MISALIGN_EN: misaligned redirects raise a sticky flag and stall fetch.
module prefetch_unit
    import core_pkg::*;
#(
    parameter int ADDRESS_BITS = CORE_ADDRESS_BITS,
    parameter int DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = ADDRESS_BITS'(CORE_RESET_PC)
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_resp_valid,
    input  logic [INSTR_BITS-1:0]   imem_resp_data,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [INSTR_BITS-1:0]   inst_data,
    output logic [ADDRESS_BITS-1:0] inst_pc,
    output logic                    misaligned
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [INSTR_BITS-1:0]   instr;
    } entry_t;

    logic [ADDRESS_BITS-1:0] r_fetch_pc;
    logic [ADDRESS_BITS-1:0] r_resp_pc;
    logic [CW-1:0]           r_outst;
    logic [CW-1:0]           r_drop;

    logic [CW-1:0]           w_occ;
    logic [CW:0]             w_in_use;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_block;
    logic [ADDRESS_BITS-1:0] w_redirect_pc;
    logic [CW-1:0]           w_outst_left;
    entry_t                  w_push_entry;
    entry_t                  w_head;

`ifdef PREFETCH_MISALIGN_EN
    logic r_misaligned;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              r_misaligned <= 1'b0;
        else if (redirect_valid) r_misaligned <= |redirect_pc[1:0];
    end

    assign w_redirect_pc = redirect_pc;
    assign w_block       = r_misaligned;
    assign misaligned    = r_misaligned;
`else
    logic w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^redirect_pc[1:0];
    assign w_redirect_pc    = {redirect_pc[ADDRESS_BITS-1:2], 2'b00};
    assign w_block          = 1'b0;
    assign misaligned       = 1'b0;
`endif

    // In-flight requests plus buffered words may never exceed DEPTH, so a push always finds room.
    assign w_in_use = {1'b0, w_occ} + {1'b0, r_outst};

    // NOTE: gating with reset keeps the request low while reset is held, not just after the first edge.
    assign imem_req_valid = reset && !redirect_valid && !w_block
                            && (w_in_use < (CW + 1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_push         = imem_resp_valid && (r_drop == '0) && !redirect_valid;
    assign w_outst_left   = r_outst - CW'(imem_resp_valid);

    assign w_push_entry = '{pc: r_resp_pc, instr: imem_resp_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (inst_ready),
        .o_valid (inst_valid),
        .o_data  (w_head),
        .o_occ   (w_occ)
    );

    assign inst_pc   = w_head.pc;
    assign inst_data = w_head.instr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_outst    <= w_outst_left;
            r_drop     <= w_outst_left;
        end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + ADDRESS_BITS'(4);
            if (w_push)   r_resp_pc  <= r_resp_pc + ADDRESS_BITS'(4);
            if (imem_resp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            r_outst <= r_outst + CW'(w_accept) - CW'(imem_resp_valid);
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: queue-based stream model plus directed and random traffic.
module tb_prefetch_unit;

    localparam int AB    = 16;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AB-1:0] imem_req_addr;
    logic          imem_resp_valid = 1'b0;
    logic [31:0]   imem_resp_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AB-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [31:0]   inst_data;
    logic [AB-1:0] inst_pc;
    logic          misaligned;

    always #5 clock = ~clock;

    prefetch_unit #(.ADDRESS_BITS(AB), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .misaligned      (misaligned)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_fn(input logic [AB-1:0] a);
        return {~a, a} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [AB-1:0] fix_pc(input logic [AB-1:0] p);
`ifdef PREFETCH_MISALIGN_EN
        return p;
`else
        return p & 16'hFFFC;
`endif
    endfunction

    // Instruction memory environment: in-order responses, per-request latency >= 1 cycle.
    typedef struct {
        logic [AB-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc      = 0;
    int    last_due = 0;
    int    lat_lo   = 1;
    int    lat_hi   = 1;

    task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [AB-1:0] rpc);
        int due;
        @(negedge clock);
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_fn(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            mq.push_back('{addr: imem_req_addr, due: due});
            last_due = due;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        inst_ready      = 1'b0;
        mq.delete();
        last_due = cyc;
        #1;
        check("async_clear_inst_valid", 64'(inst_valid), 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    // Reference model: the delivered stream is redirect target + 4k with data read from that address;
    // requests in flight at a redirect are marked stale and never reach decode.
    typedef struct {
        logic [AB-1:0] pc;
        logic [31:0]   data;
    } ent_t;

    ent_t          m_fifo[$];
    bit            m_stale[$];
    logic [AB-1:0] m_fetch = '0;
    logic [AB-1:0] m_resp  = '0;
    bit            m_mis   = 1'b0;
    bit            exp_rv;
    bit            s;

    always @(negedge clock) begin
        #2;
        if (!reset) begin
            m_fifo.delete();
            m_stale.delete();
            m_fetch = '0;
            m_resp  = '0;
            m_mis   = 1'b0;
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check("rst_inst_valid", 64'(inst_valid), 64'd0);
            check("rst_misaligned", 64'(misaligned), 64'd0);
        end else begin
            exp_rv = !redirect_valid && !m_mis && (m_fifo.size() + m_stale.size() < DEPTH);
            check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
            if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(m_fetch));
            check("inst_valid", 64'(inst_valid), 64'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                check("inst_pc", 64'(inst_pc), 64'(m_fifo[0].pc));
                check("inst_data", 64'(inst_data), 64'(m_fifo[0].data));
            end
            check("misaligned", 64'(misaligned), 64'(m_mis));

            if (redirect_valid) begin
                m_fifo.delete();
                if (imem_resp_valid && m_stale.size() > 0) void'(m_stale.pop_front());
                foreach (m_stale[i]) m_stale[i] = 1'b1;
                m_fetch = fix_pc(redirect_pc);
                m_resp  = fix_pc(redirect_pc);
`ifdef PREFETCH_MISALIGN_EN
                m_mis = |redirect_pc[1:0];
`endif
            end else begin
                if (inst_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
                if (imem_resp_valid && m_stale.size() > 0) begin
                    s = m_stale.pop_front();
                    if (!s) begin
                        m_fifo.push_back('{pc: m_resp, data: mem_fn(m_resp)});
                        m_resp = m_resp + 16'd4;
                    end
                end
                if (exp_rv && imem_req_ready) begin
                    m_stale.push_back(1'b0);
                    m_fetch = m_fetch + 16'd4;
                end
            end
        end
    end

    initial begin
        int            accepts;
        int            pops;
        logic [AB-1:0] nxt_pc;
        logic [AB-1:0] nxt_addr;
        logic [31:0]   r32;
        logic [AB-1:0] rpc;

        // Reset held: no request, no instruction.
        repeat (2) @(negedge clock);
        #3;
        check("hold_req_valid", 64'(imem_req_valid), 64'd0);
        check("hold_inst_valid", 64'(inst_valid), 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // Release with 1-cycle memory: requests 0,4,8..; first instruction two cycles later.
        lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            check("t1_req_valid", 64'(imem_req_valid), 64'd1);
            check("t1_req_addr", 64'(imem_req_addr), 64'(4 * k));
            check("t1_inst_valid", 64'(inst_valid), 64'(k >= 2));
            if (k >= 2) check("t1_inst_pc", 64'(inst_pc), 64'(4 * (k - 2)));
        end

        // Decode stalled: exactly DEPTH requests, then the buffer holds them all.
        do_reset();
        accepts = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            if (imem_req_valid) accepts++;
        end
        check("t2_accepts", 64'(accepts), 64'd4);
        check("t2_req_blocked", 64'(imem_req_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            check("t2_drain_valid", 64'(inst_valid), 64'd1);
            check("t2_drain_pc", 64'(inst_pc), 64'(4 * k));
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("t2_empty", 64'(inst_valid), 64'd0);

        // 3-cycle memory, redirect to 0x100 with two requests outstanding.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 16'h0100);
        check("t3_no_req_on_redirect", 64'(imem_req_valid), 64'd0);
        for (int k = 3; k <= 8; k++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (k == 3) check("t3_first_req", 64'(imem_req_addr), 64'h100);
            check("t3_inst_valid", 64'(inst_valid), 64'(k >= 7));
            if (k == 7) begin
                check("t3_first_pc", 64'(inst_pc), 64'h100);
                check("t3_first_data", 64'(inst_data), 64'(mem_fn(16'h0100)));
            end
            if (k == 8) check("t3_second_pc", 64'(inst_pc), 64'h104);
        end

        // Redirect coinciding with a response and a pop.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 16'h0040);
        check("t4_pop_valid", 64'(inst_valid), 64'd1);
        check("t4_resp_present", 64'(imem_resp_valid), 64'd1);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check("t4_flushed", 64'(inst_valid), 64'd0);
        check("t4_req_valid", 64'(imem_req_valid), 64'd1);
        check("t4_req_addr", 64'(imem_req_addr), 64'h40);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check("t4_still_empty", 64'(inst_valid), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check("t4_new_pc", 64'(inst_pc), 64'h40);

        // Memory ready toggling: no skipped or repeated addresses.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        nxt_pc = '0; nxt_addr = '0; pops = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(k % 2 == 0, 1'b1, 1'b0, '0);
            if (imem_req_valid && imem_req_ready) begin
                check("t5_req_seq", 64'(imem_req_addr), 64'(nxt_addr));
                nxt_addr = nxt_addr + 16'd4;
            end
            if (inst_valid) begin
                check("t5_pop_seq", 64'(inst_pc), 64'(nxt_pc));
                nxt_pc = nxt_pc + 16'd4;
                pops++;
            end
        end
        check("t5_enough_pops", 64'(pops >= 10), 64'd1);

        // Misaligned redirect handling.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 1'b1, 1'b1, 16'h0102);
`ifdef PREFETCH_MISALIGN_EN
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            check("t6_flag_set", 64'(misaligned), 64'd1);
            check("t6_req_blocked", 64'(imem_req_valid), 64'd0);
        end
        cycle(1'b1, 1'b1, 1'b1, 16'h0200);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check("t6_flag_clear", 64'(misaligned), 64'd0);
        check("t6_resume_valid", 64'(imem_req_valid), 64'd1);
        check("t6_resume_addr", 64'(imem_req_addr), 64'h200);
`else
        cycle(1'b1, 1'b1, 1'b0, '0);
        check("t6_forced_align", 64'(imem_req_addr), 64'h100);
        check("t6_flag_tied", 64'(misaligned), 64'd0);
`endif

        // Random traffic against the model, with one reset in the middle.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            r32 = $urandom;
            rpc = r32[15:0];
            if ($urandom_range(99, 0) < 80) rpc[1:0] = 2'b00;
            cycle($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70,
                  $urandom_range(99, 0) < 4, rpc);
        end

        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
